// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank driver: FSM state encoding,
// JK excitation codes and the try-counter width.
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    STROBE,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam int TRY_W = 3;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request / completion handshake between the command front end (master)
// and the JK bank driver (slave).
import jk_pkg::*;

interface jk_bank_driver_if #(
  parameter int W = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [W-1:0]     req_data;
  logic             done_valid;
  logic             done_ok;
  logic [TRY_W-1:0] done_tries;

  modport master (
    output req_valid, req_mode, req_data,
    input  req_ready, done_valid, done_ok, done_tries
  );

  modport slave (
    input  req_valid, req_mode, req_data,
    output req_ready, done_valid, done_ok, done_tries
  );
endinterface

// File: rtl/jk_excite.sv
// Per-bit JK excitation: maps current Q and target T to the J/K pair that
// moves Q to T on the next strobe. Build option JK_BANK_TOGGLE_EN drives
// changing bits with the toggle code instead of set/reset.
import jk_pkg::*;

module jk_excite (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  logic [1:0] jk_code;

  // Select the excitation code for this bit.
  always_comb begin
    jk_code = JK_HOLD;
`ifdef JK_BANK_TOGGLE_EN
    if (q != t) begin
      jk_code = JK_TGL;
    end
`else
    if (q != t) begin
      jk_code = t ? JK_SET : JK_RST;
    end
`endif
  end

  assign j = jk_code[1];
  assign k = jk_code[0];
endmodule

// File: rtl/jk_bank_driver.sv
// Initiator-side controller for a bank of W JK flip-flops. Accepts a write
// request (exact word or toggle mask), drives J/K with a one-cycle strobe,
// verifies Q against the target and retries up to MAX_RETRY times.
// Optional build macro: JK_BANK_TOGGLE_EN (toggle excitation, see jk_excite).
import jk_pkg::*;

module jk_bank_driver #(
  parameter int W         = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  jk_bank_driver_if.slave       req_if,
  input  logic [W-1:0]          jk_q,
  output logic [W-1:0]          jk_j,
  output logic [W-1:0]          jk_k,
  output logic                  jk_strobe
);

  localparam logic [TRY_W-1:0] RETRY_LIMIT = TRY_W'(MAX_RETRY);

  state_t           state_reg, state_next;
  logic [W-1:0]     target_reg;
  logic             mode_reg;
  logic [TRY_W-1:0] try_reg;
  logic [W-1:0]     j_reg, k_reg;
  logic             done_ok_reg;
  logic [TRY_W-1:0] done_tries_reg;

  logic             ready_c, strobe_c, done_fire, done_pass;
  logic             resolve;
  logic             match;
  logic [W-1:0]     tgt_eff;
  logic [W-1:0]     j_calc, k_calc;

  // Toggle-mask requests hold the mask in target_reg until the first CALC,
  // which folds in the live Q; retries reuse the already resolved target.
  assign resolve = (state_reg == CALC) && mode_reg && (try_reg == '0);
  assign tgt_eff = resolve ? (jk_q ^ target_reg) : target_reg;
  assign match   = (jk_q == target_reg);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      jk_excite u_excite (
        .q (jk_q[gi]),
        .t (tgt_eff[gi]),
        .j (j_calc[gi]),
        .k (k_calc[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/strobe/completion decode.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    strobe_c   = 1'b0;
    done_fire  = 1'b0;
    done_pass  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        if (req_if.req_valid) begin
          state_next = CALC;
        end
      end
      CALC:   state_next = STROBE;
      STROBE: begin
        strobe_c   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: state_next = CHECK;
      CHECK: begin
        done_pass = match;
        if (match || (try_reg > RETRY_LIMIT)) begin
          done_fire  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = CALC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, excitation registers, try counter and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_reg     <= '0;
      mode_reg       <= 1'b0;
      try_reg        <= '0;
      j_reg          <= '0;
      k_reg          <= '0;
      done_ok_reg    <= 1'b0;
      done_tries_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_if.req_valid) begin
            mode_reg   <= req_if.req_mode;
            target_reg <= req_if.req_data;
            try_reg    <= '0;
          end
        end
        CALC: begin
          target_reg <= tgt_eff;
          j_reg      <= j_calc;
          k_reg      <= k_calc;
        end
        STROBE: try_reg <= try_reg + TRY_W'(1);
        SETTLE: begin
          j_reg <= '0;
          k_reg <= '0;
        end
        CHECK: begin
          if (done_fire) begin
            done_ok_reg    <= done_pass;
            done_tries_reg <= try_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_if.req_ready  = ready_c;
  assign req_if.done_valid = done_fire;
  assign req_if.done_ok    = done_fire ? done_pass : done_ok_reg;
  assign req_if.done_tries = done_fire ? try_reg : done_tries_reg;
  assign jk_strobe         = strobe_c;
  assign jk_j              = j_reg;
  assign jk_k              = k_reg;

endmodule
